// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_if
//  Description : Bus bundle for the fetch controller. It carries the
//                instruction-memory request/ack channel and the
//                instr/instr_valid/instr_ready handoff to decode.
//                master : fetch controller side
//                slave  : memory + decode side
//  Signals     : imem_req, imem_addr[31:0]   request to instruction memory
//                imem_ack, imem_rdata[31:0]  memory response
//                instr[31:0], instr_valid    instruction offered to decode
//                instr_ready                 decode accepts instr
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction fetch controller. It issues one memory request at
//                a time, hands each fetched word to decode, drives PC
//                increment/branch pulses, and handles redirects, halt and
//                a sticky memory-timeout fault. All outputs are registered.
//  Parameters  : ACK_TIMEOUT  unanswered request cycles before FAULT (1..255)
//  Ports       : clk, rst            clock, synchronous active-high reset
//                start               begin/resume fetching (IDLE/HALT)
//                halt_req            halt after the current handoff
//                redirect, redirect_addr[31:0]  restart fetch at target
//                pc[31:0]            current PC from the PC block
//                pc_inc, pc_branch   PC advance / PC load pulses
//                pc_addr[31:0]       branch target for the PC block
//                halted, fault       status
//                bus                 imem + decode handshakes (master)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  input  wire logic        halt_req,
  input  wire logic        redirect,
  input  wire logic [31:0] redirect_addr,
  input  wire logic [31:0] pc,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic [31:0]      pc_addr,
  output logic             halted,
  output logic             fault,
  fetch_ctrl_if.master     bus
);

  // Last unanswered count that still leaves room for one more cycle.
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_REDIR = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_pc_inc, r_pc_branch, r_imem_req, r_instr_valid, r_halted, r_fault;
  logic [31:0] r_pc_addr, r_imem_addr, r_instr;
  logic        w_pc_inc, w_pc_branch, w_imem_req, w_instr_valid, w_halted, w_fault;
  logic [31:0] w_pc_addr, w_imem_addr, w_instr;
  logic [31:0] w_pc_next;
  logic        w_timeout;
  logic        w_handshake;

  // The PC block reacts to our pulses at the same edge that our address
  // register samples, so forward the value pc will hold next cycle.
  assign w_pc_next   = r_pc_inc ? (pc + 32'd4) : (r_pc_branch ? r_pc_addr : pc);
  assign w_timeout   = (r_cnt >= c_TIMEOUT_LAST);
  assign w_handshake = r_instr_valid & bus.instr_ready;

  // Next-state logic; redirect outranks ack, ack outranks timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_REQ;
      S_REQ: begin
        if (redirect)          w_state_nxt = S_REDIR;
        else if (bus.imem_ack) w_state_nxt = S_HOLD;
        else if (w_timeout)    w_state_nxt = S_FAULT;
      end
      S_HOLD: begin
        if (redirect)         w_state_nxt = S_REDIR;
        else if (w_handshake) w_state_nxt = halt_req ? S_HALT : S_REQ;
      end
      S_REDIR: if (!redirect) w_state_nxt = S_REQ;
      S_HALT:  if (start) w_state_nxt = S_REQ;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    w_pc_inc      = 1'b0;
    w_pc_branch   = 1'b0;
    w_pc_addr     = r_pc_addr;
    w_imem_req    = 1'b0;
    w_imem_addr   = 32'd0;
    w_instr       = r_instr;
    w_instr_valid = 1'b0;
    w_halted      = 1'b0;
    w_fault       = 1'b0;
    w_cnt_nxt     = 8'd0;
    case (w_state_nxt)
      S_REQ: begin
        w_imem_req  = 1'b1;
        w_imem_addr = w_pc_next;
        // Counter restarts on every entry into REQ.
        if (r_state == S_REQ) w_cnt_nxt = r_cnt + 8'd1;
      end
      S_HOLD: begin
        w_instr_valid = 1'b1;
        // Capture and pulse only on the REQ->HOLD transition.
        if (r_state == S_REQ) begin
          w_instr  = bus.imem_rdata;
          w_pc_inc = 1'b1;
        end
      end
      S_REDIR: begin
        w_pc_branch = 1'b1;
        w_pc_addr   = redirect_addr;
      end
      S_HALT:  w_halted = 1'b1;
      S_FAULT: begin
        w_fault   = 1'b1;
        w_instr   = 32'd0;
        w_pc_addr = 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_inc      <= 1'b0;
      r_pc_branch   <= 1'b0;
      r_pc_addr     <= 32'd0;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= 32'd0;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_pc_inc      <= w_pc_inc;
      r_pc_branch   <= w_pc_branch;
      r_pc_addr     <= w_pc_addr;
      r_imem_req    <= w_imem_req;
      r_imem_addr   <= w_imem_addr;
      r_instr       <= w_instr;
      r_instr_valid <= w_instr_valid;
      r_halted      <= w_halted;
      r_fault       <= w_fault;
    end
  end

  assign pc_inc          = r_pc_inc;
  assign pc_branch       = r_pc_branch;
  assign pc_addr         = r_pc_addr;
  assign halted          = r_halted;
  assign fault           = r_fault;
  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_imem_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: cycles of unanswered imem_req before FAULT; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  begin/resume fetching from IDLE or HALT.
REQ-005 halt_req  input  1  stop after the current instruction is handed off.
REQ-006 redirect  input  1  branch/jump taken; restart fetch at redirect_addr.
REQ-007 redirect_addr  input  32  redirect target.
REQ-008 pc  input  32  current PC from the PC block.
REQ-009 pc_inc  output  1  one-cycle pulse: PC block advances by 4.
REQ-010 pc_branch  output  1  one-cycle pulse: PC block loads pc_addr.
REQ-011 pc_addr  output  32  branch target to the PC block.
REQ-012 imem_req  output  1  instruction memory request; held until ack or cancel.
REQ-013 imem_addr  output  32  request address.
REQ-014 imem_ack  input  1  memory returns imem_rdata this cycle; only meaningful while imem_req=1.
REQ-015 imem_rdata  input  32  fetched instruction.
REQ-016 instr  output  32  instruction to decode.
REQ-017 instr_valid  output  1  instr valid; held until instr_ready.
REQ-018 instr_ready  input  1  decode accepts instr.
REQ-019 halted  output  1  high in HALT.
REQ-020 fault  output  1  sticky memory-timeout flag.

Function
REQ-021 States SHALL be IDLE, REQ, HOLD, REDIR, HALT, FAULT; all outputs SHALL be registered.
REQ-022 IDLE: start=1 -> REQ next cycle; halt_req ignored.
REQ-023 REQ: imem_req=1, imem_addr=pc every cycle; timeout counter cleared on entry, +1 per cycle without imem_ack.
REQ-024 REQ with imem_ack=1 and redirect=0: instr<=imem_rdata, instr_valid=1 and pc_inc=1 the next cycle, state HOLD; imem_req low in HOLD.
REQ-025 pc_inc SHALL be high exactly one cycle per accepted instruction, coincident with the first instr_valid cycle.
REQ-026 HOLD: instr and instr_valid stable until instr_valid&instr_ready; on that handshake, halt_req=1 -> HALT, else REQ next cycle.
REQ-027 Fetch-to-fetch minimum: ack to next imem_req rising SHALL be 2 cycles with instr_ready tied high (pc already incremented when REQ resumes).
REQ-028 redirect=1 in REQ or HOLD: next state REDIR; instr_valid cleared next cycle; any same-cycle imem_ack discarded, no pc_inc; imem_req low next cycle (cancel).
REQ-029 REDIR: pc_branch=1, pc_addr=captured redirect_addr for exactly one cycle, then REQ; redirect during REDIR recaptures address and stays in REDIR one more cycle.
REQ-030 redirect in IDLE, HALT or FAULT SHALL be ignored.
REQ-031 Timeout: counter reaching ACK_TIMEOUT with no ack -> FAULT; imem_ack in that same cycle wins (normal accept).
REQ-032 Priority: rst > redirect > imem_ack > timeout; redirect beats halt_req in HOLD, halt_req re-evaluated at next handshake.
REQ-033 HALT: halted=1, no requests; start=1 -> REQ.
REQ-034 FAULT: fault=1, all other outputs 0; exit only by rst.
REQ-035 At most one of pc_inc, pc_branch SHALL be high in any cycle.

Reset
REQ-036 rst=1 at any edge SHALL force IDLE, counter 0, instr=0, and pc_inc, pc_branch, pc_addr, imem_req, imem_addr, instr_valid, halted, fault all 0 on the next cycle, including mid-request or mid-redirect.
REQ-037 While rst=1, start, redirect, imem_ack SHALL be ignored.

Verification
REQ-038 pc=0x1234, start, ack after 2 cycles with rdata=0xDEADBEEF, instr_ready=1 -> instr=0xDEADBEEF valid one cycle, pc_inc one pulse, imem_req reasserted 2 cycles after ack.
REQ-039 instr_ready low 3 cycles in HOLD -> instr_valid held 3+ cycles, instr stable, no second imem_req, single pc_inc.
REQ-040 redirect=1 with redirect_addr=0x80 in same cycle as imem_ack -> no instr_valid, no pc_inc, pc_branch one pulse with pc_addr=0x80, then imem_req.
REQ-041 ACK_TIMEOUT=4, no ack -> fault=1 after 4 REQ cycles, stays until rst; ack on 4th cycle -> normal accept, fault=0.
REQ-042 halt_req=1 during HOLD, handshake -> halted=1, no imem_req; start -> fetch resumes at current pc.
REQ-043 rst asserted while imem_req=1 -> all outputs 0 next cycle, state IDLE, late imem_ack ignored.
